d3s_acq_capture_wb: RTL and testbench
=====================================

D3S_ACQ_CAPTURE_WB -- requirements
Module: d3s_acq_capture_wb

Interface
REQ-001 Parameter g_size, default 128, SHALL set the buffer depth in samples; it SHALL be a power of two from 16 to 4096.
REQ-002 Parameter g_data_width, default 16, SHALL set the sample width; it SHALL be no more than 32.
REQ-003 clk_sys_i  in  1  SHALL be the single system clock; all logic SHALL be on its rising edge.
REQ-004 rst_n_i  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 data_i  in  g_data_width  SHALL carry the ADC sample.
REQ-006 data_valid_i  in  1  SHALL qualify data_i for one cycle.
REQ-007 trigger_i  in  1  SHALL be a synchronous trigger pulse; it SHALL exist only when D3S_ACQ_TRIGGER_EN is defined.
REQ-008 wb_adr_i  in  2  SHALL be the word address: 0 = ACQ_CR, 1 = ACQ_ADDR, 2 = ACQ_DATA, 3 = reserved.
REQ-009 wb_dat_i / wb_dat_o  in / out  32 / 32  SHALL carry Wishbone write and read data.
REQ-010 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  SHALL be the Wishbone pipelined-slave controls.
REQ-011 wb_sel_i  in  4  SHALL be ignored; every access SHALL be full-word.
REQ-012 wb_ack_o, wb_stall_o  out  1 each  SHALL be the Wishbone acknowledge and stall.

Function
REQ-013 ACQ_CR SHALL be laid out as follows:
- bit0 START: write-1 pulse, reads 0.
- bit1 READY: read-only.
- bit2 BUSY: read-only.
- bits[31:3]: read 0.
REQ-014 The FSM SHALL have states IDLE, ARMED (macro builds only), CAPTURE and DONE.
REQ-015 An ACQ_CR write with bit0=1 SHALL take effect as follows:
- clear READY and the write pointer;
- enter ARMED in trigger builds, otherwise CAPTURE;
- apply from any state, including a restart mid-CAPTURE.
REQ-016 In CAPTURE, each cycle with data_valid_i=1 SHALL write data_i to RAM[wr_ptr] and increment wr_ptr.
REQ-017 When the write of sample g_size-1 occurs, the FSM SHALL enter DONE on the next edge; no further samples SHALL be written.
REQ-018 In DONE, READY SHALL be 1 and BUSY SHALL be 0; DONE SHALL persist until the next START.
REQ-019 BUSY SHALL be 1 in ARMED and CAPTURE.
REQ-020 data_valid_i SHALL be ignored outside CAPTURE.
REQ-021 ACQ_ADDR SHALL be read/write; only the low log2(g_size) bits SHALL be stored, so higher bits wrap silently, and reads SHALL return the stored value zero-extended.
REQ-022 An ACQ_DATA read SHALL return RAM[ACQ_ADDR] zero-extended; writes to ACQ_DATA SHALL be acknowledged and discarded.
REQ-023 ACQ_DATA reads during CAPTURE SHALL be permitted and return the RAM content at that moment.
REQ-024 Reserved-address reads SHALL return 0; reserved-address writes SHALL be acknowledged and ignored.
REQ-025 Register accesses (CR, ADDR, reserved) SHALL acknowledge 1 cycle after the strobe.
REQ-026 ACQ_DATA reads SHALL acknowledge 2 cycles after the strobe (registered RAM read).
REQ-027 wb_stall_o SHALL be 1 while an access is outstanding, allowing one access in flight.
REQ-028 wb_ack_o SHALL be a single-cycle pulse, and only while wb_cyc_i=1.
REQ-029 If wb_cyc_i drops with an access outstanding, the pending ack SHALL be suppressed.
REQ-030 A capture write and a Wishbone RAM read in the same cycle SHALL both proceed; the read SHALL return the old data.

Reset
REQ-031 On rst_n_i low, the following SHALL be cleared asynchronously:
- FSM to IDLE;
- READY=0, BUSY=0;
- wr_ptr=0, ACQ_ADDR=0;
- wb_ack_o=0, wb_stall_o=0, wb_dat_o=0.
REQ-032 RAM contents SHALL NOT be cleared by reset.
REQ-033 A reset asserted mid-CAPTURE SHALL abort the capture; READY SHALL stay 0 until a new START completes.

Configuration
REQ-034 With D3S_ACQ_TRIGGER_EN defined, START SHALL enter ARMED, and trigger_i=1 in ARMED SHALL enter CAPTURE.
REQ-035 If trigger_i and data_valid_i coincide in ARMED, that coincident sample SHALL NOT be stored; the first stored sample SHALL be the next valid one.
REQ-036 Without D3S_ACQ_TRIGGER_EN, the ARMED state and the trigger_i port SHALL not exist, and START SHALL enter CAPTURE directly.

Structure
REQ-037 Package d3s_acq_pkg SHALL hold:
- the register word addresses;
- the CR bit positions (START=0, READY=1, BUSY=2);
- the FSM state enum.
REQ-038 Storage SHALL be a sub-module d3s_acq_dpram: simple dual-port, one clock, registered read port, depth g_size, width g_data_width.

Verification
REQ-039 Reset, then read CR -> 0x0, ack 1 cycle after strobe.
REQ-040 START, then feed 128 valid samples 0x0000..0x007F -> CR reads 0x2; ACQ_ADDR=5 then ACQ_DATA read -> 0x00000005, ack 2 cycles after strobe.
REQ-041 Write ACQ_ADDR=0x85 with g_size=128 -> ADDR reads 0x05; ACQ_DATA read -> 0x00000005.
REQ-042 START after 40 samples, then 128 samples starting at 0x1000 -> RAM[0]=0x1000, RAM[127]=0x107F.
REQ-043 rst_n_i pulsed at sample 60 -> CR reads 0x0, and stays 0x0 with data_valid_i still toggling.
REQ-044 Trigger build: START, 10 valid samples 0xA0..0xA9, trigger_i coincident with 0xAA -> BUSY=1 before the trigger; RAM[0]=0xAB.

Source files
------------

// File: rtl/d3s_acq_pkg.sv
// Shared definitions for the acquisition capture block: register map, CR bit positions, FSM states.
// The ARMED state only exists when D3S_ACQ_TRIGGER_EN is defined.
package d3s_acq_pkg;

    localparam logic [1:0] ADDR_CR   = 2'd0;
    localparam logic [1:0] ADDR_ADDR = 2'd1;
    localparam logic [1:0] ADDR_DATA = 2'd2;
    localparam logic [1:0] ADDR_RSVD = 2'd3;

    localparam int CR_START = 0;
    localparam int CR_READY = 1;
    localparam int CR_BUSY  = 2;

`ifdef D3S_ACQ_TRIGGER_EN
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } acq_state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } acq_state_t;
`endif

endpackage

// File: rtl/d3s_acq_dpram.sv
// Simple dual-port sample buffer: one write port, one registered read port, single clock.
// A read and a write to the same address in one cycle return the old content.
module d3s_acq_dpram #(
    parameter int g_size       = 128,
    parameter int g_data_width = 16
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(g_size)-1:0]  wr_addr,
    input  logic [g_data_width-1:0]    wr_data,
    input  logic                       re,
    input  logic [$clog2(g_size)-1:0]  rd_addr,
    output logic [g_data_width-1:0]    rd_data
);

    logic [g_data_width-1:0] mem [g_size];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (re) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/d3s_acq_capture_wb.sv
// ADC sample capture buffer with a pipelined Wishbone slave (CR / ADDR / DATA registers).
// Define D3S_ACQ_TRIGGER_EN to add trigger_i and the ARMED state between START and CAPTURE.
module d3s_acq_capture_wb
    import d3s_acq_pkg::*;
#(
    parameter int g_size       = 128,
    parameter int g_data_width = 16
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_n_i,
    input  logic [g_data_width-1:0] data_i,
    input  logic                    data_valid_i,
`ifdef D3S_ACQ_TRIGGER_EN
    input  logic                    trigger_i,
`endif
    input  logic [1:0]              wb_adr_i,
    input  logic [31:0]             wb_dat_i,
    output logic [31:0]             wb_dat_o,
    input  logic                    wb_cyc_i,
    input  logic                    wb_stb_i,
    input  logic                    wb_we_i,
    input  logic [3:0]              wb_sel_i,
    output logic                    wb_ack_o,
    output logic                    wb_stall_o
);

    localparam int AW = $clog2(g_size);

    if (g_size < 16 || g_size > 4096 || (g_size & (g_size - 1)) != 0) begin : g_bad_size
        $error("g_size must be a power of two between 16 and 4096");
    end
    if (g_data_width < 1 || g_data_width > 32) begin : g_bad_width
        $error("g_data_width must be between 1 and 32");
    end

    acq_state_t              state_reg;
    logic [AW-1:0]           wr_ptr_reg;
    logic                    ready_reg;
    logic                    busy_reg;
    logic [AW-1:0]           addr_reg;
    logic                    ack_reg;
    logic                    stall_reg;
    logic                    data_pend_reg;
    logic [31:0]             dat_reg;
    logic [31:0]             reg_rdata;
    logic [g_data_width-1:0] ram_rd_data;
    logic                    accept;
    logic                    start;
    logic                    ram_rd;
    logic                    ram_we;
    logic                    unused_bits;

    assign unused_bits = &{1'b0, wb_sel_i, wb_dat_i[31:AW]};

    assign accept = wb_cyc_i && wb_stb_i && !stall_reg;
    assign start  = accept && wb_we_i && (wb_adr_i == ADDR_CR) && wb_dat_i[CR_START];
    assign ram_rd = accept && !wb_we_i && (wb_adr_i == ADDR_DATA);
    // A START in the same cycle as a sample wins: the pointer restarts and that sample is dropped.
    assign ram_we = (state_reg == ST_CAPTURE) && data_valid_i && !start;

    assign wb_ack_o   = ack_reg && wb_cyc_i;
    assign wb_stall_o = stall_reg;
    assign wb_dat_o   = dat_reg;

    d3s_acq_dpram #(
        .g_size       (g_size),
        .g_data_width (g_data_width)
    ) u_ram (
        .clk     (clk_sys_i),
        .we      (ram_we),
        .wr_addr (wr_ptr_reg),
        .wr_data (data_i),
        .re      (ram_rd),
        .rd_addr (addr_reg),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg  <= ST_IDLE;
            wr_ptr_reg <= '0;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b0;
        end else if (start) begin
            wr_ptr_reg <= '0;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b1;
`ifdef D3S_ACQ_TRIGGER_EN
            state_reg  <= ST_ARMED;
`else
            state_reg  <= ST_CAPTURE;
`endif
        end else begin
            case (state_reg)
`ifdef D3S_ACQ_TRIGGER_EN
                // The sample coincident with the trigger is not stored.
                ST_ARMED: begin
                    if (trigger_i) begin
                        state_reg <= ST_CAPTURE;
                    end
                end
`endif
                ST_CAPTURE: begin
                    if (data_valid_i) begin
                        wr_ptr_reg <= wr_ptr_reg + AW'(1);
                        if (&wr_ptr_reg) begin
                            state_reg <= ST_DONE;
                            ready_reg <= 1'b1;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        reg_rdata = '0;
        case (wb_adr_i)
            ADDR_CR: begin
                reg_rdata[CR_READY] = ready_reg;
                reg_rdata[CR_BUSY]  = busy_reg;
            end
            ADDR_ADDR: reg_rdata = 32'(addr_reg);
            default: ;
        endcase
    end

    // One access in flight: stall rises on accept and falls after the ack cycle.
    always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_reg       <= 1'b0;
            stall_reg     <= 1'b0;
            data_pend_reg <= 1'b0;
            dat_reg       <= '0;
            addr_reg      <= '0;
        end else begin
            ack_reg <= 1'b0;
            if (!wb_cyc_i) begin
                stall_reg     <= 1'b0;
                data_pend_reg <= 1'b0;
            end else if (accept) begin
                stall_reg <= 1'b1;
                if (ram_rd) begin
                    data_pend_reg <= 1'b1;
                end else begin
                    ack_reg <= 1'b1;
                    if (!wb_we_i) begin
                        dat_reg <= reg_rdata;
                    end
                end
                if (wb_we_i && (wb_adr_i == ADDR_ADDR)) begin
                    addr_reg <= wb_dat_i[AW-1:0];
                end
            end else if (data_pend_reg) begin
                data_pend_reg <= 1'b0;
                ack_reg       <= 1'b1;
                dat_reg       <= 32'(ram_rd_data);
            end else if (stall_reg) begin
                stall_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_d3s_acq_capture_wb.sv
// Randomized self-checking bench for d3s_acq_capture_wb against a sample-list reference model.
// Define D3S_ACQ_TRIGGER_EN to also exercise the armed/trigger path.
module tb_d3s_acq_capture_wb;

    localparam int SIZE = 128;
    localparam int DW   = 16;
`ifdef D3S_ACQ_TRIGGER_EN
    localparam bit TRIG = 1'b1;
    logic trigger = 1'b0;
`else
    localparam bit TRIG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] data = '0;
    logic          data_valid = 1'b0;
    logic [1:0]    adr = '0;
    logic [31:0]   dat_w = '0;
    logic [31:0]   dat_r;
    logic          cyc = 1'b0;
    logic          stb = 1'b0;
    logic          we = 1'b0;
    logic [3:0]    sel = 4'hF;
    logic          ack;
    logic          stall;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: the buffer holds the first SIZE valid samples seen after the last START.
    logic [DW-1:0] m_ram [SIZE];
    bit            m_known [SIZE];
    int            m_count = 0;
    bit            m_active = 1'b0;
    bit            m_armed = 1'b0;

    always #5 clk = ~clk;

    d3s_acq_capture_wb #(
        .g_size       (SIZE),
        .g_data_width (DW)
    ) dut (
        .clk_sys_i    (clk),
        .rst_n_i      (rst_n),
        .data_i       (data),
        .data_valid_i (data_valid),
`ifdef D3S_ACQ_TRIGGER_EN
        .trigger_i    (trigger),
`endif
        .wb_adr_i     (adr),
        .wb_dat_i     (dat_w),
        .wb_dat_o     (dat_r),
        .wb_cyc_i     (cyc),
        .wb_stb_i     (stb),
        .wb_we_i      (we),
        .wb_sel_i     (sel),
        .wb_ack_o     (ack),
        .wb_stall_o   (stall)
    );

    function automatic logic [31:0] model_cr();
        logic [31:0] v;
        v = 32'h0;
        v[2] = m_armed || (m_active && m_count < SIZE);
        v[1] = m_active && m_count == SIZE;
        return v;
    endfunction

    function automatic void model_sample(input logic [DW-1:0] d);
        if (m_active && m_count < SIZE) begin
            m_ram[m_count]   = d;
            m_known[m_count] = 1'b1;
            m_count++;
        end
    endfunction

    task automatic wb_access(input logic w, input logic [1:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output int lat);
        int waits;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_w = wd;
        waits = 0;
        while (stall && waits < 10) begin
            @(negedge clk);
            waits++;
        end
        @(posedge clk);
        @(negedge clk);
        stb = 1'b0;
        lat = 1;
        while (!ack && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        if (!ack) lat = -1;
        rd = dat_r;
        cyc = 1'b0; we = 1'b0;
        $display("[TB] %s adr=%0d wdat=%08h rdat=%08h lat=%0d", w ? "WR" : "RD", a, wd, rd, lat);
    endtask

    task automatic read_ram(input int idx, output logic [31:0] rd, output int lat);
        logic [31:0] dummy;
        int l0;
        wb_access(1'b1, 2'd1, 32'(idx), dummy, l0);
        wb_access(1'b0, 2'd2, 32'h0, rd, lat);
    endtask

    task automatic do_start();
        logic [31:0] dummy;
        int l0;
        wb_access(1'b1, 2'd0, 32'h1, dummy, l0);
        m_count = 0; m_active = !TRIG; m_armed = TRIG;
`ifdef D3S_ACQ_TRIGGER_EN
        @(negedge clk); trigger = 1'b1;
        @(negedge clk); trigger = 1'b0;
        m_armed = 1'b0; m_active = 1'b1;
`endif
    endtask

    task automatic feed(input int n, input bit rnd, input logic [DW-1:0] base, input int gap_pct);
        int k;
        k = 0;
        while (k < n) begin
            @(negedge clk);
            if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                data_valid = 1'b0;
                data = DW'($urandom);
            end else begin
                data_valid = 1'b1;
                data = rnd ? DW'($urandom) : base + DW'(k);
                model_sample(data);
                k++;
            end
        end
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        int lat;
        #2 rst_n = 1'b0;
        m_active = 1'b0; m_armed = 1'b0; m_count = 0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({ack, stall, dat_r} !== 34'h0) begin
            tests_failed++;
            $display("FAIL reset_outputs ack=%b stall=%b dat=%08h want all 0", ack, stall, dat_r);
        end
        rst_n = 1'b1;
        wb_access(1'b0, 2'd0, 32'h0, rd, lat);
        tests_run++;
        if (rd !== 32'h0 || lat !== 1) begin
            tests_failed++;
            $display("FAIL reset_cr got=%08h lat=%0d want=00000000 lat=1", rd, lat);
        end
        wb_access(1'b0, 2'd1, 32'h0, rd, lat);
        tests_run++;
        if (rd !== 32'h0 || lat !== 1) begin
            tests_failed++;
            $display("FAIL reset_addr got=%08h lat=%0d want=00000000 lat=1", rd, lat);
        end
    endtask

    task automatic test_capture_basic();
        logic [31:0] rd;
        int lat;
        do_start();
        wb_access(1'b0, 2'd0, 32'h0, rd, lat);
        tests_run++;
        if (rd !== 32'h4) begin
            tests_failed++;
            $display("FAIL basic_busy got=%08h want=00000004", rd);
        end
        feed(SIZE, 1'b0, 16'h0000, 0);
        wb_access(1'b0, 2'd0, 32'h0, rd, lat);
        tests_run++;
        if (rd !== 32'h2) begin
            tests_failed++;
            $display("FAIL basic_ready got=%08h want=00000002", rd);
        end
        read_ram(5, rd, lat);
        tests_run++;
        if (rd !== 32'h5 || lat !== 2) begin
            tests_failed++;
            $display("FAIL basic_data5 got=%08h lat=%0d want=00000005 lat=2", rd, lat);
        end
        feed(20, 1'b1, 16'h0, 0);
        read_ram(0, rd, lat);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL basic_no_overwrite got=%08h want=00000000", rd);
        end
        read_ram(SIZE - 1, rd, lat);
        tests_run++;
        if (rd !== 32'h7F) begin
            tests_failed++;
            $display("FAIL basic_last got=%08h want=0000007f", rd);
        end
    endtask

    task automatic test_addr_wrap();
        logic [31:0] rd;
        int lat;
        wb_access(1'b1, 2'd1, 32'h85, rd, lat);
        wb_access(1'b0, 2'd1, 32'h0, rd, lat);
        tests_run++;
        if (rd !== 32'h5) begin
            tests_failed++;
            $display("FAIL addr_wrap got=%08h want=00000005", rd);
        end
        wb_access(1'b0, 2'd2, 32'h0, rd, lat);
        tests_run++;
        if (rd !== 32'h5) begin
            tests_failed++;
            $display("FAIL addr_wrap_data got=%08h want=00000005", rd);
        end
        wb_access(1'b1, 2'd1, 32'hFFFF_FFFF, rd, lat);
        wb_access(1'b0, 2'd1, 32'h0, rd, lat);
        tests_run++;
        if (rd !== 32'(SIZE - 1)) begin
            tests_failed++;
            $display("FAIL addr_wrap_ones got=%08h want=%08h", rd, 32'(SIZE - 1));
        end
    endtask

    task automatic test_random_capture();
        logic [31:0] rd;
        logic [31:0] old;
        int lat, idx;
        do_start();
        feed(50, 1'b1, 16'h0, 30);
        wb_access(1'b0, 2'd0, 32'h0, rd, lat);
        tests_run++;
        if (rd !== model_cr()) begin
            tests_failed++;
            $display("FAIL rnd_mid_cr got=%08h want=%08h", rd, model_cr());
        end
        idx = $urandom_range(m_count - 1);
        read_ram(idx, rd, lat);
        tests_run++;
        if (rd !== 32'(m_ram[idx])) begin
            tests_failed++;
            $display("FAIL rnd_mid_read[%0d] got=%08h want=%08h", idx, rd, 32'(m_ram[idx]));
        end
        // Read the slot being written in the same cycle: old content must come back.
        idx = m_count;
        wb_access(1'b1, 2'd1, 32'(idx), rd, lat);
        old = 32'(m_ram[idx]);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd2;
        data_valid = 1'b1; data = DW'($urandom);
        model_sample(data);
        @(negedge clk);
        stb = 1'b0; data_valid = 1'b0;
        lat = 1;
        while (!ack && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        tests_run++;
        if (dat_r !== old || lat !== 2) begin
            tests_failed++;
            $display("FAIL rnd_collision got=%08h lat=%0d want=%08h lat=2", dat_r, lat, old);
        end
        cyc = 1'b0;
        read_ram(idx, rd, lat);
        tests_run++;
        if (rd !== 32'(m_ram[idx])) begin
            tests_failed++;
            $display("FAIL rnd_collision_new got=%08h want=%08h", rd, 32'(m_ram[idx]));
        end
        feed(SIZE - m_count, 1'b1, 16'h0, 30);
        wb_access(1'b0, 2'd0, 32'h0, rd, lat);
        tests_run++;
        if (rd !== model_cr()) begin
            tests_failed++;
            $display("FAIL rnd_end_cr got=%08h want=%08h", rd, model_cr());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat, idx;
        for (int i = 0; i < 8; i++) begin
            idx = $urandom_range(SIZE - 1);
            read_ram(idx, rd, lat);
            tests_run++;
            if (rd !== 32'(m_ram[idx]) || lat !== 2) begin
                tests_failed++;
                $display("FAIL b2b_read[%0d] got=%08h lat=%0d want=%08h lat=2", idx, rd, lat, 32'(m_ram[idx]));
            end
        end
        idx = $urandom_range(SIZE - 1);
        wb_access(1'b1, 2'd1, 32'(idx), rd, lat);
        wb_access(1'b1, 2'd2, $urandom, rd, lat);
        wb_access(1'b1, 2'd3, $urandom, rd, lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL rsvd_write_ack lat=%0d want=1", lat);
        end
        wb_access(1'b0, 2'd3, 32'h0, rd, lat);
        tests_run++;
        if (rd !== 32'h0 || lat !== 1) begin
            tests_failed++;
            $display("FAIL rsvd_read got=%08h lat=%0d want=00000000 lat=1", rd, lat);
        end
        wb_access(1'b0, 2'd2, 32'h0, rd, lat);
        tests_run++;
        if (rd !== 32'(m_ram[idx])) begin
            tests_failed++;
            $display("FAIL data_write_discard got=%08h want=%08h", rd, 32'(m_ram[idx]));
        end
    endtask

    task automatic test_restart();
        logic [31:0] rd;
        int lat;
        do_start();
        feed(40, 1'b1, 16'h0, 0);
        do_start();
        feed(SIZE, 1'b0, 16'h1000, 20);
        read_ram(0, rd, lat);
        tests_run++;
        if (rd !== 32'h1000) begin
            tests_failed++;
            $display("FAIL restart_first got=%08h want=00001000", rd);
        end
        read_ram(SIZE - 1, rd, lat);
        tests_run++;
        if (rd !== 32'h107F) begin
            tests_failed++;
            $display("FAIL restart_last got=%08h want=0000107f", rd);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd;
        int lat, idx;
        do_start();
        feed(60, 1'b1, 16'h0, 0);
        @(negedge clk); rst_n = 1'b0;
        m_active = 1'b0; m_armed = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        wb_access(1'b0, 2'd0, 32'h0, rd, lat);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL rstmid_cr got=%08h want=00000000", rd);
        end
        feed(40, 1'b1, 16'h0, 50);
        wb_access(1'b0, 2'd0, 32'h0, rd, lat);
        tests_run++;
        if (rd !== 32'h0) begin
            tests_failed++;
            $display("FAIL rstmid_cr_stays got=%08h want=00000000", rd);
        end
        idx = 30 + $urandom_range(60);
        read_ram(idx, rd, lat);
        tests_run++;
        if (rd !== 32'(m_ram[idx])) begin
            tests_failed++;
            $display("FAIL rstmid_ram_kept[%0d] got=%08h want=%08h", idx, rd, 32'(m_ram[idx]));
        end
    endtask

    task automatic test_cyc_drop();
        logic [31:0] rd;
        int lat;
        bit saw_ack;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 2'd2;
        @(negedge clk);
        stb = 1'b0;
        tests_run++;
        if (stall !== 1'b1 || ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_stall stall=%b ack=%b want stall=1 ack=0", stall, ack);
        end
        cyc = 1'b0;
        saw_ack = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (ack) saw_ack = 1'b1;
        end
        tests_run++;
        if (saw_ack || stall !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_suppress ack_seen=%b stall=%b want 0 0", saw_ack, stall);
        end
        wb_access(1'b0, 2'd1, 32'h0, rd, lat);
        tests_run++;
        if (lat !== 1) begin
            tests_failed++;
            $display("FAIL drop_recover lat=%0d want=1", lat);
        end
    endtask

`ifdef D3S_ACQ_TRIGGER_EN
    task automatic test_trigger();
        logic [31:0] rd;
        int lat;
        wb_access(1'b1, 2'd0, 32'h1, rd, lat);
        m_count = 0; m_active = 1'b0; m_armed = 1'b1;
        feed(10, 1'b0, 16'h00A0, 0);
        wb_access(1'b0, 2'd0, 32'h0, rd, lat);
        tests_run++;
        if (rd !== 32'h4) begin
            tests_failed++;
            $display("FAIL trig_armed_busy got=%08h want=00000004", rd);
        end
        @(negedge clk);
        data = 16'h00AA; data_valid = 1'b1; trigger = 1'b1;
        m_armed = 1'b0; m_active = 1'b1;
        @(negedge clk);
        trigger = 1'b0; data_valid = 1'b0;
        feed(SIZE, 1'b0, 16'h00AB, 0);
        read_ram(0, rd, lat);
        tests_run++;
        if (rd !== 32'hAB) begin
            tests_failed++;
            $display("FAIL trig_first got=%08h want=000000ab", rd);
        end
        wb_access(1'b0, 2'd0, 32'h0, rd, lat);
        tests_run++;
        if (rd !== 32'h2) begin
            tests_failed++;
            $display("FAIL trig_ready got=%08h want=00000002", rd);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_capture_basic();
        test_addr_wrap();
        test_random_capture();
        test_back_to_back();
        test_restart();
        test_reset_mid();
        test_cyc_drop();
`ifdef D3S_ACQ_TRIGGER_EN
        test_trigger();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
